// File: rtl/soc_rst_pkg.sv
// Shared types for the SoC reset sequencer: FSM state encoding and status counter width.
// The optional status outputs are enabled with SOC_RST_SEQ_STATUS_EN.
package soc_rst_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } rst_state_t;

    localparam int RETRY_W = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_rst_seq_if.sv
// Signal bundle between the reset sequencer and its environment (PLL and reset consumers).
// Status signals exist only with SOC_RST_SEQ_STATUS_EN.
interface soc_rst_seq_if;
    // All signals are levels sampled on the board clock; there is no valid/ready
    // handshake. i_pll_lock may change at any time, i_sw_rst_req is honoured only in RUN.
    logic                    pll_lock;
    logic                    sw_rst_req;
    logic                    pll_rst;
    logic                    sys_rst_n;
    logic                    ready;
    soc_rst_pkg::rst_state_t state;
`ifdef SOC_RST_SEQ_STATUS_EN
    logic [soc_rst_pkg::RETRY_W-1:0] retry_cnt;
    logic                            fault;
`endif

    modport master (
        input  pll_lock, sw_rst_req,
`ifdef SOC_RST_SEQ_STATUS_EN
        output retry_cnt, fault,
`endif
        output pll_rst, sys_rst_n, ready, state
    );

    modport slave (
        output pll_lock, sw_rst_req,
`ifdef SOC_RST_SEQ_STATUS_EN
        input  retry_cnt, fault,
`endif
        input  pll_rst, sys_rst_n, ready, state
    );

endinterface

// File: rtl/soc_rst_seq_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; both stages reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_rst_seq.sv
// SoC reset sequencer: pulses PLL reset, waits for a stable lock, then releases system reset.
// Define SOC_RST_SEQ_STATUS_EN to add the o_retry_cnt / o_fault status outputs.
module soc_rst_seq
    import soc_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic               i_clk_50m,
    input  logic               i_rst_n,
    input  logic               i_pll_lock,
    input  logic               i_sw_rst_req,
    output logic               o_pll_rst,
    output logic               o_sys_rst_n,
    output logic               o_ready,
`ifdef SOC_RST_SEQ_STATUS_EN
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_fault,
`endif
    output rst_state_t         o_dbg_state
);

    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic             lock_s;
    rst_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (i_clk_50m),
        .rst_n (i_rst_n),
        .d     (i_pll_lock),
        .q     (lock_s)
    );

    // Every state leaves before its counter limit, so the counter never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!lock_s || i_sw_rst_req) begin
                    state_nxt = ST_PLL_RST;
                end
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            o_pll_rst   <= 1'b1;
            o_sys_rst_n <= 1'b0;
            o_ready     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            o_pll_rst   <= (state_nxt == ST_PLL_RST);
            o_sys_rst_n <= (state_nxt == ST_RUN);
            o_ready     <= (state_nxt == ST_RUN);
        end
    end

    assign o_dbg_state = state;

`ifdef SOC_RST_SEQ_STATUS_EN
    logic               retry_evt;
    logic [RETRY_W-1:0] retry_nxt;

    // A software request alone is not a retry; lock loss in RUN is, even with a request.
    assign retry_evt = !lock_s && (((state == ST_WAIT_LOCK) && (cnt == TO_LAST)) ||
                                   (state == ST_RUN));
    assign retry_nxt = (retry_evt && (o_retry_cnt != RETRY_MAX)) ? o_retry_cnt + 1'b1
                                                                 : o_retry_cnt;

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_retry_cnt <= '0;
            o_fault     <= 1'b0;
        end else begin
            o_retry_cnt <= retry_nxt;
            o_fault     <= o_fault | (retry_nxt == RETRY_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_soc_rst_seq.sv
// Self-checking bench for soc_rst_seq with short cycle parameters (4 / 8 / 32).
// Status checks are compiled in when SOC_RST_SEQ_STATUS_EN is defined.
module tb_soc_rst_seq;
    import soc_rst_pkg::*;

    localparam int P_PLL  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 32;
    localparam int PERIOD = P_PLL + P_TO;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    soc_rst_seq_if rif();

    soc_rst_seq #(
        .PLL_RST_CYCLES      (P_PLL),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TO)
    ) dut (
        .i_clk_50m    (clk),
        .i_rst_n      (rst_n),
        .i_pll_lock   (rif.pll_lock),
        .i_sw_rst_req (rif.sw_rst_req),
        .o_pll_rst    (rif.pll_rst),
        .o_sys_rst_n  (rif.sys_rst_n),
        .o_ready      (rif.ready),
`ifdef SOC_RST_SEQ_STATUS_EN
        .o_retry_cnt  (rif.retry_cnt),
        .o_fault      (rif.fault),
`endif
        .o_dbg_state  (rif.state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        int lock_tick;  // lock first driven high before this edge (1 = already high in reset)
        int rel;        // edge after which o_sys_rst_n / o_ready are high
        int pll2;       // first edge of a second PLL reset pulse after a timeout, 0 = none
        int sw_tick;    // edge at which i_sw_rst_req is pulsed, 0 = none
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic pll, input logic sys);
        exp_q.push_back({pll, sys, sys});
    endtask

    task automatic check_out(input string name, input int k);
        logic [2:0] e;
        logic [2:0] a;
        checks++;
        a = {rif.pll_rst, rif.sys_rst_n, rif.ready};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s tick %0d: no expected value queued, got %b", name, k, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s tick %0d: {pll_rst,sys_rst_n,ready} got %b expected %b",
                         name, k, a, e);
            end
        end
    endtask

    task automatic chk_val(input string name, input int k, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tick %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold_reset(input logic lock);
        @(negedge clk);
        rst_n          = 1'b0;
        rif.pll_lock   = lock;
        rif.sw_rst_req = 1'b0;
        tick();
        tick();
        push_exp(1'b1, 1'b0);
        check_out("reset", 0);
        chk_val("reset state", 0, int'(rif.state), int'(ST_PLL_RST));
`ifdef SOC_RST_SEQ_STATUS_EN
        chk_val("reset retry", 0, int'(rif.retry_cnt), 0);
        chk_val("reset fault", 0, int'(rif.fault), 0);
`endif
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int extra);
        hold_reset(v.lock_tick <= 1);
        for (int k = 1; k <= v.rel + extra; k++) begin
            if (k == v.lock_tick) rif.pll_lock = 1'b1;
            rif.sw_rst_req = (k == v.sw_tick);
            push_exp((k <= P_PLL - 1) || (v.pll2 > 0 && k >= v.pll2 && k <= v.pll2 + P_PLL - 1),
                     k >= v.rel);
            tick();
            check_out($sformatf("vec lock@%0d", v.lock_tick), k);
`ifdef SOC_RST_SEQ_STATUS_EN
            chk_val("vec retry", k, int'(rif.retry_cnt), (v.pll2 > 0 && k >= v.pll2) ? 1 : 0);
`endif
        end
        rif.sw_rst_req = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        rif.pll_lock   = 1'b0;
        rif.sw_rst_req = 1'b0;

        vecs[0] = '{1,  13, 0,  0};
        vecs[1] = '{5,  15, 0,  0};
        vecs[2] = '{12, 22, 0,  0};
        vecs[3] = '{34, 44, 0,  0};
        vecs[4] = '{35, 49, 36, 0};
        vecs[5] = '{20, 30, 0,  10};

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 3);

        // Lock never asserts: periodic PLL reset pulses.
        hold_reset(1'b0);
        for (int k = 1; k <= 3 * PERIOD + 6; k++) begin
            push_exp((k % PERIOD) <= P_PLL - 1, 1'b0);
            tick();
            check_out("no lock", k);
`ifdef SOC_RST_SEQ_STATUS_EN
            chk_val("no lock retry", k, int'(rif.retry_cnt), k / PERIOD);
`endif
        end

        // One-cycle lock glitch while STABLE counter is at 5.
        hold_reset(1'b0);
        for (int k = 1; k <= 25; k++) begin
            if (k == 5)  rif.pll_lock = 1'b1;
            if (k == 11) rif.pll_lock = 1'b0;
            if (k == 12) rif.pll_lock = 1'b1;
            push_exp(k <= P_PLL - 1, k >= 22);
            tick();
            check_out("glitch", k);
        end

        // Reach RUN, then lose lock.
        run_vec(vecs[0], 3);
        rif.pll_lock = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 4) rif.pll_lock = 1'b1;
            push_exp(j >= 3 && j <= 6, j <= 2 || j >= 16);
            tick();
            check_out("lock loss", j);
`ifdef SOC_RST_SEQ_STATUS_EN
            chk_val("lock loss retry", j, int'(rif.retry_cnt), (j >= 3) ? 1 : 0);
`endif
        end

        // Software request in RUN re-sequences without counting a retry.
        for (int j = 1; j <= 18; j++) begin
            rif.sw_rst_req = (j == 1);
            push_exp(j <= P_PLL, j >= 14);
            tick();
            check_out("sw req run", j);
`ifdef SOC_RST_SEQ_STATUS_EN
            chk_val("sw req retry", j, int'(rif.retry_cnt), 1);
`endif
        end
        rif.sw_rst_req = 1'b0;

        // Asynchronous reset in RUN: outputs drop before the next edge.
        #2 rst_n = 1'b0;
        #1;
        push_exp(1'b1, 1'b0);
        check_out("async rst run", 0);

        // Asynchronous reset mid-STABLE.
        hold_reset(1'b1);
        for (int k = 1; k <= 9; k++) begin
            push_exp(k <= P_PLL - 1, 1'b0);
            tick();
            check_out("pre stable", k);
        end
        chk_val("mid stable state", 9, int'(rif.state), int'(ST_STABLE));
        #2 rst_n = 1'b0;
        #1;
        push_exp(1'b1, 1'b0);
        check_out("async rst stable", 9);
        chk_val("async rst state", 9, int'(rif.state), int'(ST_PLL_RST));
        run_vec(vecs[0], 2);

`ifdef SOC_RST_SEQ_STATUS_EN
        // Saturate the retry counter with repeated timeouts.
        hold_reset(1'b0);
        for (int k = 1; k <= 256 * PERIOD + 1; k++) begin
            tick();
            if (k == 254 * PERIOD + 1) begin
                chk_val("sat retry 254", k, int'(rif.retry_cnt), 254);
                chk_val("sat fault low", k, int'(rif.fault), 0);
            end
            if (k == 255 * PERIOD) begin
                chk_val("sat retry 255", k, int'(rif.retry_cnt), 255);
                chk_val("sat fault high", k, int'(rif.fault), 1);
            end
            if (k == 256 * PERIOD + 1) begin
                chk_val("sat retry hold", k, int'(rif.retry_cnt), 255);
                chk_val("sat fault sticky", k, int'(rif.fault), 1);
                chk_val("sat still retrying", k, int'(rif.pll_rst), 1);
            end
        end
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_rst_seq.md
SOC_RST_SEQ -- requirements
Module: soc_rst_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; both are listed first below.
REQ-002 Parameter PLL_RST_CYCLES SHALL default to 16 and set the number of cycles o_pll_rst is held high per attempt.
REQ-003 Parameter LOCK_STABLE_CYCLES SHALL default to 1024 and set the number of consecutive synchronized-lock-high cycles required before system release.
REQ-004 Parameter LOCK_TIMEOUT_CYCLES SHALL default to 65536 and set the maximum number of WAIT_LOCK cycles per attempt.
REQ-005 Port i_clk_50m SHALL be an input, 1 bit: the 50 MHz board clock; all logic is clocked on its rising edge.
REQ-006 Port i_rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port i_pll_lock SHALL be an input, 1 bit: PLL LOCK, asynchronous to i_clk_50m.
REQ-008 Port i_sw_rst_req SHALL be an input, 1 bit: software/system request for a full re-sequence.
REQ-009 Port o_pll_rst SHALL be an output, 1 bit: active-high drive to the PLL RESET pin.
REQ-010 Port o_sys_rst_n SHALL be an output, 1 bit: active-low reset for all PLL-clocked domains.
REQ-011 Port o_ready SHALL be an output, 1 bit: high only in state RUN.

Function
REQ-012 i_pll_lock SHALL pass through a two-flop synchronizer; the FSM uses only its output, lock_s.
REQ-013 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE and RUN, and one shared cycle counter.
REQ-014 PLL_RST: o_pll_rst=1; after PLL_RST_CYCLES cycles -> WAIT_LOCK, counter cleared.
REQ-015 WAIT_LOCK: if lock_s=1 -> STABLE, counter cleared; otherwise, on counter==LOCK_TIMEOUT_CYCLES-1 -> PLL_RST (retry).
REQ-016 STABLE: lock_s=0 -> WAIT_LOCK, counter cleared, timeout restarted; lock_s=1 with counter==LOCK_STABLE_CYCLES-1 -> RUN.
REQ-017 RUN: lock_s=0 or i_sw_rst_req=1 -> PLL_RST; lock loss takes priority over the request, with the same result.
REQ-018 i_sw_rst_req SHALL be ignored outside RUN.
REQ-019 All outputs SHALL be registered and decoded from the next state: o_pll_rst=1 only in PLL_RST; o_sys_rst_n=1 and o_ready=1 only in RUN.
REQ-020 If N is the first edge that samples i_pll_lock high in WAIT_LOCK, o_sys_rst_n SHALL rise after edge N+2+LOCK_STABLE_CYCLES.
REQ-021 On leaving RUN, o_sys_rst_n SHALL be low after the next edge.
REQ-022 The counter SHALL be $clog2 of the largest cycle parameter wide and SHALL never wrap; it clears on every state change.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately force state PLL_RST, counter 0, synchronizer flops 0, o_pll_rst=1, o_sys_rst_n=0 and o_ready=0, in any state.
REQ-024 After i_rst_n is released, sequencing SHALL start from PLL_RST with a full PLL_RST_CYCLES hold.

Configuration
REQ-025 With SOC_RST_SEQ_STATUS_EN defined, the block SHALL add output o_retry_cnt (8 bits) and output o_fault (1 bit).
REQ-026 o_retry_cnt SHALL increment, saturating at 255, on each WAIT_LOCK timeout and each RUN lock loss; it is cleared only by i_rst_n.
REQ-027 o_fault SHALL be sticky high once o_retry_cnt reaches 255; the FSM keeps retrying.
REQ-028 Without SOC_RST_SEQ_STATUS_EN, neither port nor its logic SHALL exist, and the FSM behaviour SHALL be identical.

Structure
REQ-029 The state enum and the status counter width SHALL live in the shared package soc_rst_pkg.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (parameterized width, active-low async reset, resets to 0).

Verification (bench parameters PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-031 Release i_rst_n with lock held high -> o_pll_rst high for 4 cycles; o_sys_rst_n rises 10 edges after lock is first sampled; o_ready=1.
REQ-032 Lock never asserts -> o_pll_rst pulses 4 cycles every 36 cycles; with STATUS_EN, o_retry_cnt=1,2,3...
REQ-033 Lock glitches low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK; release happens 8 full cycles after lock_s returns high.
REQ-034 Drop lock in RUN -> o_sys_rst_n=0 and o_ready=0 within 3 edges (2 sync + 1); full re-sequence follows.
REQ-035 Pulse i_sw_rst_req in RUN, and separately in WAIT_LOCK -> re-sequence from RUN; no effect in WAIT_LOCK.
REQ-036 Assert i_rst_n mid-STABLE -> outputs reach their reset values asynchronously, before the next edge; force 256 timeouts with STATUS_EN -> o_retry_cnt=255 and o_fault=1.
